// File: rtl/usr_pkg.sv
// Shared types and constants for the universal shift register family.
package usr_pkg;

  typedef enum logic [0:0] {
    TX_IDLE  = 1'b0,
    TX_SHIFT = 1'b1
  } tx_state_t;

  // Receiver mode encodings, used when looping the transmitter back into a shift register.
  localparam logic [1:0] MODE_LOCK = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage : usr_pkg

// File: rtl/usr_serial_tx.sv
// Parallel-in, serial-out transmitter: accepts a word on LOAD/READY and shifts it out
// one bit per clock with an SVALID strobe; HOLD freezes the frame in place.
module usr_serial_tx
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] DATAIN,
  input  logic             LOAD,
  output logic             READY,
  input  logic             HOLD,
  output logic             SDATA,
  output logic             SVALID,
  output logic             BUSY,
  output logic             TXDONE
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    count_q, count_d;
  logic             txdone_q, txdone_d;
  logic             last_bit_c;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= TX_IDLE;
      shreg_q  <= '0;
      count_q  <= '0;
      txdone_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      count_q  <= count_d;
      txdone_q <= txdone_d;
    end
  end

  // Last bit of the frame is being consumed this cycle.
  assign last_bit_c = (state_q == TX_SHIFT) && (count_q == '0) && !HOLD;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    count_d  = count_q;
    txdone_d = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (LOAD) begin
          shreg_d = DATAIN;
          count_d = CW'(WIDTH - 1);
          state_d = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        if (!HOLD) begin
          if (count_q != '0) begin
            if (LSB_FIRST) shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            else           shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            count_d = count_q - CW'(1);
          end else begin
            txdone_d = 1'b1;
            // Back-to-back accept keeps SVALID gapless across frames.
            if (LOAD) begin
              shreg_d = DATAIN;
              count_d = CW'(WIDTH - 1);
            end else begin
              state_d = TX_IDLE;
            end
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign SDATA  = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
  assign BUSY   = (state_q == TX_SHIFT);
  assign SVALID = (state_q == TX_SHIFT) && !HOLD;
  assign READY  = (state_q == TX_IDLE) || last_bit_c;
  assign TXDONE = txdone_q;

endmodule : usr_serial_tx

// File: tb/tb_usr_serial_tx.sv
// Directed bench for usr_serial_tx: LSB-first and MSB-first instances share stimulus,
// plus a behavioural right-shift receiver for loopback.
module tb_usr_serial_tx;
  import usr_pkg::*;

  localparam int unsigned W = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         load;
  logic         hold;

  logic rdy_l, sd_l, sv_l, busy_l, done_l;
  logic rdy_m, sd_m, sv_m, busy_m, done_m;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  usr_serial_tx #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clock(clock), .reset(reset), .DATAIN(din), .LOAD(load), .READY(rdy_l),
    .HOLD(hold), .SDATA(sd_l), .SVALID(sv_l), .BUSY(busy_l), .TXDONE(done_l)
  );

  usr_serial_tx #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clock(clock), .reset(reset), .DATAIN(din), .LOAD(load), .READY(rdy_m),
    .HOLD(hold), .SDATA(sd_m), .SVALID(sv_m), .BUSY(busy_m), .TXDONE(done_m)
  );

  // Receiver in right-shift mode: serial-in enters at the MSB.
  logic [1:0]   rx_mode;
  logic [W-1:0] rx_q;
  assign rx_mode = sv_l ? MODE_SHR : MODE_LOCK;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                  rx_q <= '0;
    else if (rx_mode == MODE_SHR) rx_q <= {sd_l, rx_q[W-1:1]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [W-1:0]   bits;
    logic [2*W-1:0] seq;
    logic [W-1:0]   words [3];
    logic [W-1:0]   sd_exp;
    logic [7:0]     sv_exp;
    bit             found;

    // 1. Reset with LOAD asserted.
    reset = 1'b0; load = 1'b1; hold = 1'b0; din = W'($urandom);
    #1;
    chk("rst_sdata_l", 32'(sd_l), 0);
    chk("rst_sdata_m", 32'(sd_m), 0);
    chk("rst_svalid",  32'(sv_l), 0);
    chk("rst_busy",    32'(busy_l), 0);
    chk("rst_txdone",  32'(done_l), 0);
    chk("rst_ready",   32'(rdy_l), 1);
    repeat (2) adv();
    chk("rst_clk_busy",  32'(busy_m), 0);
    chk("rst_clk_ready", 32'(rdy_m), 1);
    chk("rst_clk_done",  32'(done_m), 0);
    load = 1'b0; reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      adv(); #3;
      chk("idle_busy",  32'(busy_l), 0);
      chk("idle_ready", 32'(rdy_l), 1);
    end

    // 2. Single frame 1011: LSB-first 1,1,0,1; MSB-first 1,0,1,1.
    bits = 4'b1011; load = 1'b1; din = bits;
    adv(); load = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      #3;
      if (c <= 4) begin
        chk($sformatf("f1_sdata_l_c%0d", c), 32'(sd_l), 32'(bits[c-1]));
        chk($sformatf("f1_sdata_m_c%0d", c), 32'(sd_m), 32'(bits[W-c]));
      end
      chk($sformatf("f1_svalid_c%0d", c), 32'(sv_l),   32'(c <= 4));
      chk($sformatf("f1_ready_c%0d",  c), 32'(rdy_l),  32'(c >= 4));
      chk($sformatf("f1_busy_c%0d",   c), 32'(busy_l), 32'(c <= 4));
      chk($sformatf("f1_txdone_c%0d", c), 32'(done_l), 32'(c == 5));
      adv();
    end

    // 3. Back-to-back 1011 then 0110 with LOAD held.
    seq = 8'b0110_1011; load = 1'b1; din = 4'b1011;
    adv(); din = 4'b0110;
    for (int c = 1; c <= 9; c++) begin
      #3;
      if (c <= 8) chk($sformatf("b2b_sdata_c%0d", c), 32'(sd_l), 32'(seq[c-1]));
      chk($sformatf("b2b_svalid_c%0d", c), 32'(sv_l),   32'(c <= 8));
      chk($sformatf("b2b_txdone_c%0d", c), 32'(done_l), 32'((c == 5) || (c == 9)));
      adv();
      if (c == 4) load = 1'b0;
    end

    // 4. HOLD for two cycles after the second bit.
    sd_exp = '0;
    sv_exp = 8'b0011_0011;
    load = 1'b1; din = 4'b1011;
    adv(); load = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      hold = (c == 3) || (c == 4);
      #3;
      if (c <= 6) begin
        bits = 4'b1011;
        sd_exp[0] = (c <= 2) ? bits[c-1] : ((c <= 4) ? 1'b0 : bits[c-3]);
        chk($sformatf("hold_sdata_c%0d", c), 32'(sd_l), 32'(sd_exp[0]));
      end
      chk($sformatf("hold_svalid_c%0d", c), 32'(sv_l),   32'(sv_exp[c-1]));
      chk($sformatf("hold_busy_c%0d",   c), 32'(busy_l), 32'(c <= 6));
      chk($sformatf("hold_txdone_c%0d", c), 32'(done_l), 32'(c == 7));
      adv();
    end
    hold = 1'b0;

    // 5. Asynchronous reset after two bits.
    load = 1'b1; din = 4'b1011;
    adv(); load = 1'b0;
    #3; chk("ar_bit1", 32'(sd_l), 1);
    adv();
    #3; chk("ar_bit2", 32'(sd_l), 1);
    reset = 1'b0;
    #1;
    chk("ar_svalid", 32'(sv_l),   0);
    chk("ar_busy",   32'(busy_l), 0);
    chk("ar_sdata",  32'(sd_l),   0);
    chk("ar_ready",  32'(rdy_l),  1);
    chk("ar_busy_m", 32'(busy_m), 0);
    #2 reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      adv(); #3;
      chk("ar_no_done", 32'(done_l), 0);
      chk("ar_idle",    32'(busy_l), 0);
    end
    bits = 4'b0101; load = 1'b1; din = bits;
    adv(); load = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #3;
      if (c <= 4) chk($sformatf("ar_f2_sdata_c%0d", c), 32'(sd_l), 32'(bits[c-1]));
      chk($sformatf("ar_f2_txdone_c%0d", c), 32'(done_l), 32'(c == 5));
      adv();
    end

    // 6. Loopback into a right-shift receiver.
    words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'hF;
    for (int i = 0; i < 3; i++) begin
      load = 1'b1; din = words[i];
      adv(); load = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
        #3;
        if (done_l) begin
          found = 1'b1;
          break;
        end
        adv();
      end
      chk($sformatf("lb_done_%0d", i), 32'(found), 1);
      chk($sformatf("lb_word_%0d", i), 32'(rx_q), 32'(words[i]));
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_usr_serial_tx
